fb_write_buffer: RTL and testbench

Sits directly downstream of the colour-fill loop. It captures that stage's per-pixel frame-buffer writes: write_en, fb_addr and data_out_color, plus its done pulse. The colour loop has no backpressure, so the block absorbs writes in a small FIFO and coalesces back-to-back writes to the same pixel. It drains entries to the frame-buffer SRAM port with a req/ack handshake and reports when a chunk's writes are fully committed.

---
 rtl/fb_write_buffer_pkg.sv | 24 ++
 rtl/fb_write_buffer_fifo.sv | 66 ++++++
 rtl/fb_write_buffer.sv | 127 ++++++++++++
 tb/tb_fb_write_buffer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_write_buffer_pkg.sv
// Shared types and width defaults for the frame-buffer write path.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: Color pixel struct, frame-buffer address width and buffer depth defaults.
`ifndef FRAME_BUFFER_ADDR_SIZE
`define FRAME_BUFFER_ADDR_SIZE 16
`endif
`ifndef FB_BUF_DEPTH
`define FB_BUF_DEPTH 8
`endif

package fb_write_buffer_pkg;

  // 24-bit pixel colour as produced by the colour-fill loop.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  localparam int FB_ADDR_W    = `FRAME_BUFFER_ADDR_SIZE;
  localparam int FB_BUF_DEPTH = `FB_BUF_DEPTH;

endpackage

// File: rtl/fb_write_buffer_fifo.sv
// Circular {addr, colour} store with a colour-overwrite port on the newest entry.
// Latency: push visible at head one edge later; count is registered.
// Backpressure: none internally; the parent guarantees legal push/pop/overwrite use.
// Ports: clk/rst; push + push_addr/push_color; pop; ovr + ovr_color (rewrites tail colour);
//        head_addr/head_color (oldest); tail_addr (newest); count (occupancy).
module fb_fifo
  import fb_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ADDR_W-1:0]      push_addr,
  input  Color                   push_color,
  input  logic                   pop,
  input  logic                   ovr,
  input  Color                   ovr_color,
  output logic [ADDR_W-1:0]      head_addr,
  output Color                   head_color,
  output logic [ADDR_W-1:0]      tail_addr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  Color              color_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  tail_ptr;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  assign tail_ptr   = wr_ptr - 1'b1;
  assign head_addr  = addr_mem[rd_ptr];
  assign head_color = color_mem[rd_ptr];
  assign tail_addr  = addr_mem[tail_ptr];

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr]  <= push_addr;
      color_mem[wr_ptr] <= push_color;
    end else if (ovr) begin
      color_mem[tail_ptr] <= ovr_color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_buffer.sv
// Absorbs colour-loop pixel writes, coalesces same-pixel rewrites, drains to the FB SRAM.
// Latency: write into an empty idle buffer on cycle N is requested on cycle N+2.
// Backpressure: none upstream (writes dropped when full, sticky overflow); req/ack downstream.
// Ports: clk, rst; wr_en/wr_addr/wr_color, flush_in from the colour loop;
//        fb_req/fb_addr_out/fb_data_out with fb_ack to the SRAM; flush_done, overflow, count.
module fb_write_buffer
  import fb_write_buffer_pkg::*;
#(
  parameter int DEPTH  = `FB_BUF_DEPTH,
  parameter int ADDR_W = `FRAME_BUFFER_ADDR_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  Color                   wr_color,
  input  logic                   flush_in,
  input  logic                   fb_ack,
  output logic                   fb_req,
  output logic [ADDR_W-1:0]      fb_addr_out,
  output Color                   fb_data_out,
  output logic                   flush_done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              flush_pend;
  logic [ADDR_W-1:0] head_addr;
  Color              head_color;
  logic [ADDR_W-1:0] tail_addr;
  logic              pop;
  logic              head_locked;
  logic              coalesce;
  logic              push;
  logic              drop;
  logic              post_empty;

  // Accept decisions. The tail may only be rewritten when it is not the entry
  // currently presented to the SRAM, so the presented value stays stable.
  assign pop         = (state == BUSY) && fb_ack;
  assign head_locked = (state == BUSY) && (count == ONE);
  assign coalesce    = wr_en && (count != '0) && (wr_addr == tail_addr) && !head_locked;
  assign push        = wr_en && !coalesce && ((count != FULL) || pop);
  assign drop        = wr_en && !coalesce && !push;
  // Occupancy after this edge's pop, counting a same-cycle push.
  assign post_empty  = (count == ONE) && !push;

  fb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (wr_addr),
    .push_color (wr_color),
    .pop        (pop),
    .ovr        (coalesce),
    .ovr_color  (wr_color),
    .head_addr  (head_addr),
    .head_color (head_color),
    .tail_addr  (tail_addr),
    .count      (count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (count != '0)    state_nxt = BUSY;
        else if (flush_pend) state_nxt = DONE;
      end
      BUSY: begin
        if (pop && post_empty) state_nxt = flush_pend ? DONE : IDLE;
      end
      DONE: begin
        state_nxt = (count != '0) ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: only BUSY drives the SRAM port, only DONE pulses flush_done.
  always_comb begin
    fb_req      = 1'b0;
    fb_addr_out = '0;
    fb_data_out = '0;
    flush_done  = 1'b0;
    case (state)
      BUSY: begin
        fb_req      = 1'b1;
        fb_addr_out = head_addr;
        fb_data_out = head_color;
      end
      DONE:    flush_done = 1'b1;
      default: ;
    endcase
  end

  // A flush in the DONE cycle re-arms rather than being lost, giving a second pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (flush_in)           flush_pend <= 1'b1;
      else if (state == DONE) flush_pend <= 1'b0;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_write_buffer.sv
// Bench for fb_write_buffer: vector table, corner-case sequences, randomized run vs queue model.
// Latency: n/a.
// Backpressure: fb_ack driven by the bench.
module tb_fb_write_buffer;
  import fb_write_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0] wr_color = '0;
  logic        flush_in = 1'b0;
  logic        fb_ack = 1'b0;
  logic        fb_req;
  logic [AW-1:0] fb_addr_out;
  logic [23:0] fb_data_out;
  logic        flush_done;
  logic        overflow;
  logic [3:0]  count;

  fb_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_color    (wr_color),
    .flush_in    (flush_in),
    .fb_ack      (fb_ack),
    .fb_req      (fb_req),
    .fb_addr_out (fb_addr_out),
    .fb_data_out (fb_data_out),
    .flush_done  (flush_done),
    .overflow    (overflow),
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [23:0] c,
                       input logic fl, input logic ack);
    wr_en = wr; wr_addr = a; wr_color = c; flush_in = fl; fb_ack = ack;
  endtask

  // Vector table: inputs for a cycle plus the outputs expected in that same cycle.
  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [23:0] c;
    logic        fl;
    logic        ack;
    logic        e_req;
    logic [15:0] e_a;
    logic [23:0] e_c;
    logic [3:0]  e_cnt;
    logic        e_done;
    logic        e_ovf;
  } vec_t;

  function automatic vec_t v(logic wr, logic [15:0] a, logic [23:0] c, logic fl, logic ack,
                             logic e_req, logic [15:0] e_a, logic [23:0] e_c,
                             logic [3:0] e_cnt, logic e_done, logic e_ovf);
    vec_t r;
    r.wr = wr; r.a = a; r.c = c; r.fl = fl; r.ack = ack;
    r.e_req = e_req; r.e_a = e_a; r.e_c = e_c; r.e_cnt = e_cnt; r.e_done = e_done; r.e_ovf = e_ovf;
    return r;
  endfunction

  // Reference model: pending writes as a queue, plus "presenting", "done pulse",
  // "flush pending" and "overflow" flags advanced once per clock.
  logic [15:0] m_a[$];
  logic [23:0] m_c[$];
  bit m_pres, m_done, m_fp, m_ovf;

  task automatic model_reset();
    m_a.delete(); m_c.delete();
    m_pres = 0; m_done = 0; m_fp = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit wr, input logic [15:0] a, input logic [23:0] c,
                            input bit fl, input bit ack);
    int sz;
    bit pop, co, pu, n_pres, n_done;
    sz = m_a.size();
    pop = m_pres && ack;
    co = 0; pu = 0;
    if (wr) begin
      if (sz > 0 && a == m_a[sz-1] && !(m_pres && sz == 1)) co = 1;
      else if (sz < DEPTH || pop) pu = 1;
      else m_ovf = 1;
    end
    if (co) m_c[sz-1] = c;
    if (pop) begin void'(m_a.pop_front()); void'(m_c.pop_front()); end
    if (pu) begin m_a.push_back(a); m_c.push_back(c); end
    n_pres = m_pres; n_done = 0;
    if (m_done) n_pres = (sz > 0);
    else if (m_pres) begin
      if (pop && m_a.size() == 0) begin n_pres = 0; n_done = m_fp; end
    end else begin
      if (sz > 0) n_pres = 1;
      else if (m_fp) n_done = 1;
    end
    m_fp = fl ? 1'b1 : (m_done ? 1'b0 : m_fp);
    m_pres = n_pres; m_done = n_done;
  endtask

  task automatic model_check();
    chk("rnd_req", 32'(fb_req), 32'(m_pres));
    chk("rnd_count", 32'(count), 32'(m_a.size()));
    chk("rnd_done", 32'(flush_done), 32'(m_done));
    chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
    if (m_pres && m_a.size() > 0) begin
      chk("rnd_addr", 32'(fb_addr_out), 32'(m_a[0]));
      chk("rnd_data", 32'(fb_data_out), 32'(m_c[0]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [15:0] got_a[$];
    logic [23:0] got_c[$];
    logic [15:0] exp_a[9];
    logic [23:0] exp_c[9];
    bit any_req;
    int wr_pct[4]  = '{90, 60, 80, 30};
    int ack_pct[4] = '{20, 50, 90, 70};

    // Reset state while rst is held.
    @(negedge clk);
    chk("rst_req", 32'(fb_req), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(flush_done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_addr", 32'(fb_addr_out), 0);
    chk("rst_data", 32'(fb_data_out), 0);
    rst = 1'b0;

    //          wr  addr      color        fl ack   req ea        ec           cnt done ovf
    // single write, ack held high (ack while idle ignored)
    tbl.push_back(v(1, 16'h0010, 24'hFF0000, 0, 1,   0, 16'h0,    24'h0,       0, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 1,   0, 16'h0,    24'h0,       1, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 1,   1, 16'h0010, 24'hFF0000,  1, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    // flush on an empty buffer: pulse two cycles later
    tbl.push_back(v(0, 16'h0,    24'h0,      1, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       0, 1, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    // three writes, flush, ack every other cycle
    tbl.push_back(v(1, 16'h0040, 24'h400000, 0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    tbl.push_back(v(1, 16'h0041, 24'h410000, 0, 0,   0, 16'h0,    24'h0,       1, 0, 0));
    tbl.push_back(v(1, 16'h0042, 24'h420000, 0, 0,   1, 16'h0040, 24'h400000,  2, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      1, 1,   1, 16'h0040, 24'h400000,  3, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   1, 16'h0041, 24'h410000,  2, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 1,   1, 16'h0041, 24'h410000,  2, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   1, 16'h0042, 24'h420000,  1, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 1,   1, 16'h0042, 24'h420000,  1, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       0, 1, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    // 0x30, 0x31, 0x31: the second 0x31 coalesces behind the head
    tbl.push_back(v(1, 16'h0030, 24'h111111, 0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    tbl.push_back(v(1, 16'h0031, 24'h222222, 0, 0,   0, 16'h0,    24'h0,       1, 0, 0));
    tbl.push_back(v(1, 16'h0031, 24'h333333, 0, 0,   1, 16'h0030, 24'h111111,  2, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 1,   1, 16'h0030, 24'h111111,  2, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 1,   1, 16'h0031, 24'h333333,  1, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    // same address while it is the presented head: pushed, not coalesced
    tbl.push_back(v(1, 16'h0020, 24'h00FF00, 0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       1, 0, 0));
    tbl.push_back(v(1, 16'h0020, 24'h0000FF, 0, 0,   1, 16'h0020, 24'h00FF00,  1, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 1,   1, 16'h0020, 24'h00FF00,  2, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 1,   1, 16'h0020, 24'h0000FF,  1, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    // same address while still idle with one entry: coalesced
    tbl.push_back(v(1, 16'h0050, 24'hAAAAAA, 0, 0,   0, 16'h0,    24'h0,       0, 0, 0));
    tbl.push_back(v(1, 16'h0050, 24'hBBBBBB, 0, 0,   0, 16'h0,    24'h0,       1, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 1,   1, 16'h0050, 24'hBBBBBB,  1, 0, 0));
    tbl.push_back(v(0, 16'h0,    24'h0,      0, 0,   0, 16'h0,    24'h0,       0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), 32'(fb_req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_done", i), 32'(flush_done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
      if (tbl[i].e_req) begin
        chk($sformatf("vec%0d_addr", i), 32'(fb_addr_out), 32'(tbl[i].e_a));
        chk($sformatf("vec%0d_data", i), 32'(fb_data_out), 32'(tbl[i].e_c));
      end
      drive(tbl[i].wr, tbl[i].a, tbl[i].c, tbl[i].fl, tbl[i].ack);
    end

    // Overflow: nine distinct writes with no acks; the ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b1, 16'h0100 + 16'(i), {8'(i + 1), 8'h5A, 8'(i + 1)}, 1'b0, 1'b0);
      if (i < 8) begin exp_a[i] = 16'h0100 + 16'(i); exp_c[i] = {8'(i + 1), 8'h5A, 8'(i + 1)}; end
    end
    exp_a[8] = 16'h01FF; exp_c[8] = 24'hC0FFEE;
    @(negedge clk);
    chk("full_count", 32'(count), 8);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_req", 32'(fb_req), 1);
    chk("full_head", 32'(fb_addr_out), 32'h0100);
    // Full buffer, write and ack together: accepted, count stays at DEPTH.
    got_a.push_back(fb_addr_out); got_c.push_back(fb_data_out);
    drive(1'b1, 16'h01FF, 24'hC0FFEE, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 24'h0, 1'b0, 1'b1);
    chk("full_pushpop_count", 32'(count), 8);
    chk("full_pushpop_ovf", 32'(overflow), 1);
    for (int k = 0; k < 30; k++) begin
      if (fb_req) begin got_a.push_back(fb_addr_out); got_c.push_back(fb_data_out); end
      @(negedge clk);
    end
    chk("drain_total", 32'(got_a.size()), 9);
    for (int i = 0; i < 9 && i < got_a.size(); i++) begin
      chk($sformatf("drain%0d_addr", i), 32'(got_a[i]), 32'(exp_a[i]));
      chk($sformatf("drain%0d_data", i), 32'(got_c[i]), 32'(exp_c[i]));
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);

    // Reset mid-handshake with five entries queued.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 16'h0200 + 16'(i), 24'h123400 + 24'(i), 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("prerst_req", 32'(fb_req), 1);
    chk("prerst_count", 32'(count), 5);
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(fb_req), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    chk("midrst_addr", 32'(fb_addr_out), 0);
    @(negedge clk);
    rst = 1'b0;
    fb_ack = 1'b1;
    any_req = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fb_req) any_req = 1;
    end
    chk("postrst_no_stale_req", 32'(any_req), 0);
    chk("postrst_count", 32'(count), 0);

    // Randomized segments against the queue model, each from a fresh reset.
    for (int seg = 0; seg < 4; seg++) begin
      @(negedge clk);
      drive(1'b0, 16'h0, 24'h0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
        bit r_wr, r_fl, r_ack;
        logic [15:0] r_a;
        logic [23:0] r_c;
        @(negedge clk);
        model_check();
        r_wr  = ($urandom_range(99, 0) < wr_pct[seg]);
        r_ack = ($urandom_range(99, 0) < ack_pct[seg]);
        r_fl  = ($urandom_range(99, 0) < 5);
        r_a   = 16'h0300 + 16'($urandom_range(3, 0));
        r_c   = 24'($urandom);
        drive(r_wr, r_a, r_c, r_fl, r_ack);
        model_step(r_wr, r_a, r_c, r_fl, r_ack);
      end
    end

    @(negedge clk);
    drive(1'b0, 16'h0, 24'h0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
